spi_master_n: RTL

Native, parametrised SPI master replacing the fixed-function vendor SPI core on the 50 MHz system clock. Supports configurable word width, runtime-selectable SPI mode (CPOL/CPHA), a programmable SCLK divider and up to NUM_SS active-low slave selects. Sits between user logic and the board SPI pins, using a valid/ready request side and a one-cycle result pulse.

---
 rtl/spi_pkg.sv | 12 +
 rtl/spi_clk_gen.sv | 25 ++
 rtl/spi_master_n.sv | 137 +++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding, divider floor and select-width helper for spi_master_n.
package spi_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

    localparam int CLK_DIV_MIN = 2;

    function automatic int ss_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: half-period counter; emits a one-cycle tick every CLK_DIV enabled cycles.
module spi_clk_gen #(
    parameter int CLK_DIV = 25
) (
    input  logic clk_50mhz,
    input  logic reset,
    input  logic en_i,
    input  logic restart_i,
    output logic tick_o
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] TOP = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == TOP);
    assign cnt_d  = (restart_i || tick_o) ? '0 : (en_i ? cnt_q + 1'b1 : cnt_q);

    always_ff @(posedge clk_50mhz or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/spi_master_n.sv
// spi_master_n: parametrised SPI master with runtime CPOL/CPHA, valid/ready request side
// and a one-cycle result pulse; all pins are registered.
module spi_master_n
    import spi_pkg::*;
#(
    parameter  int DATA_W  = 8,
    parameter  int NUM_SS  = 1,
    parameter  int CLK_DIV = 25,
    localparam int SS_W    = ss_width(NUM_SS)
) (
    input  logic              clk_50mhz,
    input  logic              reset,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [SS_W-1:0]   ss_sel,
    input  logic              cpol,
    input  logic              cpha,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              SCLK,
    output logic              MOSI,
    input  logic              MISO,
    output logic [NUM_SS-1:0] SS
);

    localparam int DIV = (CLK_DIV < CLK_DIV_MIN) ? CLK_DIV_MIN : CLK_DIV;
    localparam int EW  = $clog2(2 * DATA_W + 2);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d, rx_data_q, rx_data_d;
    logic [EW-1:0]     edge_q, edge_d;
    logic [NUM_SS-1:0] ss_q, ss_d;
    logic              sclk_q, sclk_d, mosi_q, mosi_d;
    logic              cpol_q, cpol_d, cpha_q, cpha_d;
    logic              rx_valid_q, rx_valid_d;
    logic              accept, tick, lead;

    assign tx_ready = (state_q == IDLE);
    assign accept   = tx_valid && tx_ready;
    // edge_q counts completed edges, so the upcoming edge is leading when it is even
    assign lead     = !edge_q[0];

    spi_clk_gen #(
        .CLK_DIV(DIV)
    ) u_clk_gen (
        .clk_50mhz(clk_50mhz),
        .reset    (reset),
        .en_i     (state_q != IDLE),
        .restart_i(accept),
        .tick_o   (tick)
    );

    always_comb begin
        state_d    = state_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        edge_d     = edge_q;
        ss_d       = ss_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        rx_valid_d = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                state_d = SETUP;
                cpol_d  = cpol;
                cpha_d  = cpha;
                sclk_d  = cpol;
                edge_d  = '0;
                tx_sr_d = cpha ? tx_data : tx_data << 1;
                mosi_d  = !cpha && tx_data[DATA_W-1];
                for (int i = 0; i < NUM_SS; i++) ss_d[i] = (ss_sel != SS_W'(i));
            end
            SETUP, XFER: if (tick) begin
                state_d = (edge_q == LAST_EDGE) ? HOLD : XFER;
                sclk_d  = !sclk_q;
                edge_d  = edge_q + 1'b1;
                if (lead != cpha_q) rx_sr_d = {rx_sr_q[DATA_W-2:0], MISO};
                // CPHA=0 already presented the MSB, so its final trailing edge has nothing left to shift
                if (lead == cpha_q && (cpha_q || edge_q != LAST_EDGE)) begin
                    mosi_d  = tx_sr_q[DATA_W-1];
                    tx_sr_d = tx_sr_q << 1;
                end
            end
            HOLD: if (tick) begin
                state_d    = IDLE;
                ss_d       = '1;
                sclk_d     = cpol_q;
                mosi_d     = 1'b0;
                rx_data_d  = rx_sr_q;
                rx_valid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_50mhz or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            edge_q     <= '0;
            ss_q       <= '1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            edge_q     <= edge_d;
            ss_q       <= ss_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign SS       = ss_q;
    assign SCLK     = sclk_q;
    assign MOSI     = mosi_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign busy     = (state_q != IDLE) || rx_valid_q;

endmodule
